// File: rtl/demux4_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux4_reg
// Description : Registered 1-to-4 demultiplexer with valid/ready handshaking
//               and a one-entry holding register per output channel.
//               Optional per-channel drain counters: DEMUX4_REG_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module demux4_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data
`ifdef DEMUX4_REG_STATS_EN
  ,
  input  logic             cnt_clr,
  output logic [31:0]      cnt_flat
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  logic       w_in_fire;
  logic [3:0] w_wr;
  logic [3:0] w_out_fire;

  // Gated with rst_n so no handshake can be offered while reset is held.
  assign in_ready   = rst_n & (~out_valid[in_sel] | out_ready[in_sel]);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_ch
      state_t           r_state;
      logic [WIDTH-1:0] r_data;

      assign w_wr[k] = w_in_fire & (in_sel == 2'(k));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= EMPTY;
          r_data  <= '0;
        end else begin
          case (r_state)
            EMPTY: begin
              if (w_wr[k]) begin
                r_state <= FULL;
                r_data  <= in_data;
              end
            end
            FULL: begin
              // A write here implies the consumer drained this cycle.
              if (w_wr[k]) begin
                r_data <= in_data;
              end else if (w_out_fire[k]) begin
                r_state <= EMPTY;
              end
            end
            default: r_state <= EMPTY;
          endcase
        end
      end
    end
  endgenerate

  assign out_valid = {g_ch[3].r_state == FULL, g_ch[2].r_state == FULL,
                      g_ch[1].r_state == FULL, g_ch[0].r_state == FULL};
  assign out0_data = g_ch[0].r_data;
  assign out1_data = g_ch[1].r_data;
  assign out2_data = g_ch[2].r_data;
  assign out3_data = g_ch[3].r_data;

`ifdef DEMUX4_REG_STATS_EN
  generate
    for (genvar k = 0; k < 4; k++) begin : g_cnt
      logic [7:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (cnt_clr) begin
          r_cnt <= '0;
        end else if (w_out_fire[k] && (r_cnt != 8'hFF)) begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  endgenerate

  assign cnt_flat = {g_cnt[3].r_cnt, g_cnt[2].r_cnt, g_cnt[1].r_cnt, g_cnt[0].r_cnt};
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux4_reg.sv
`default_nettype none
// tb_demux4_reg: directed vectors plus a random soak, checked every cycle
// against a channel-state model and per-channel delivery queues.
module tb_demux4_reg;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [1:0]       in_sel = '0;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready = '0;
  logic [WIDTH-1:0] out0_data, out1_data, out2_data, out3_data;
`ifdef DEMUX4_REG_STATS_EN
  logic             cnt_clr = 1'b0;
  logic [31:0]      cnt_flat;
`endif

  demux4_reg #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out0_data(out0_data),
    .out1_data(out1_data),
    .out2_data(out2_data),
    .out3_data(out3_data)
`ifdef DEMUX4_REG_STATS_EN
    ,
    .cnt_clr  (cnt_clr),
    .cnt_flat (cnt_flat)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: what each channel holds, plus the words still owed to each consumer.
  logic             m_valid [4];
  logic [WIDTH-1:0] m_data  [4];
  logic [WIDTH-1:0] sb      [4][$];
  logic [WIDTH-1:0] dout    [4];

  assign dout[0] = out0_data;
  assign dout[1] = out1_data;
  assign dout[2] = out2_data;
  assign dout[3] = out3_data;

  always @(negedge clk) begin
    if (run) begin
      logic             exp_rdy;
      logic [WIDTH-1:0] w;
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) begin
          m_valid[k] = 1'b0;
          m_data[k]  = '0;
          sb[k].delete();
        end
      end
      exp_rdy = rst_n && (!m_valid[in_sel] || out_ready[in_sel]);
      chk("in_ready", int'(in_ready), int'(exp_rdy));
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("out_valid[%0d]", k), int'(out_valid[k]), int'(m_valid[k]));
        chk($sformatf("out%0d_data", k), int'(dout[k]), int'(m_data[k]));
      end
      if (rst_n) begin
        for (int k = 0; k < 4; k++) begin
          if (out_valid[k] && out_ready[k]) begin
            if (sb[k].size() == 0) begin
              chk($sformatf("dup_or_misroute ch%0d", k), 1, 0);
            end else begin
              w = sb[k].pop_front();
              chk($sformatf("delivered ch%0d", k), int'(dout[k]), int'(w));
            end
          end
        end
        for (int k = 0; k < 4; k++) begin
          if (m_valid[k] && out_ready[k]) m_valid[k] = 1'b0;
        end
        if (in_valid && exp_rdy) begin
          m_valid[in_sel] = 1'b1;
          m_data[in_sel]  = in_data;
          sb[in_sel].push_back(in_data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit fired;
    for (int k = 0; k < 4; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
    end
    #1 rst_n = 1'b0;
    run = 1'b1;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // 1. Asynchronous reset mid-operation
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hAA; cyc();
    in_sel = 2'd3; in_data = 8'h55; cyc();
    in_valid = 1'b0;
    chk("pre-reset out_valid", int'(out_valid), 32'h9);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", int'(out_valid), 0);
    chk("async rst out0_data", int'(out0_data), 0);
    chk("async rst out3_data", int'(out3_data), 0);
    chk("in_ready in reset", int'(in_ready), 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // 2. Single word to channel 2, then blocked second word
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; out_ready = 4'h0;
    #1 chk("t2 in_ready", int'(in_ready), 1);
    cyc();
    chk("t2 out_valid", int'(out_valid), 32'h4);
    chk("t2 out2_data", int'(out2_data), 32'hA5);
    in_data = 8'h3C;
    #1 chk("t2 blocked in_ready", int'(in_ready), 0);
    cyc();
    chk("t2 out2 held", int'(out2_data), 32'hA5);
    in_valid = 1'b0;

    // 3. Free channel 0 while channel 2 is blocked
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h11;
    #1 chk("t3 in_ready", int'(in_ready), 1);
    cyc();
    in_valid = 1'b0;
    chk("t3 out_valid", int'(out_valid), 32'h5);
    chk("t3 out0_data", int'(out0_data), 32'h11);

    // 4. Pass-through on channel 1
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h01; cyc();
    out_ready = 4'h2;
    chk("t4 consumer 01", int'(out1_data), 32'h01);
    for (int i = 2; i <= 4; i++) begin
      in_data = 8'(i);
      #1 chk("t4 in_ready", int'(in_ready), 1);
      cyc();
      chk("t4 consumer", int'(out1_data), i);
    end
    in_valid = 1'b0;
    cyc();
    chk("t4 ch1 empty", int'(out_valid[1]), 0);
    out_ready = 4'hF;
    cyc();

    // 5. Random soak
    fired = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!(in_valid && !fired)) begin
        in_valid = ($urandom_range(0, 9) < 6);
        in_sel   = 2'($urandom_range(0, 3));
        in_data  = 8'($urandom);
      end
      out_ready = 4'($urandom);
      #1 fired = in_valid && in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 4'hF;
    repeat (3) cyc();
    chk("soak all drained", int'(out_valid), 0);
    for (int k = 0; k < 4; k++) chk($sformatf("soak sb%0d empty", k), sb[k].size(), 0);

`ifdef DEMUX4_REG_STATS_EN
    // 6. Drain counters
    cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
    chk("cnt cleared", int'(cnt_flat), 0);
    in_valid = 1'b1; in_sel = 2'd3; out_ready = 4'h8;
    for (int i = 0; i < 300; i++) begin
      in_data = 8'(i);
      cyc();
    end
    in_valid = 1'b0; cyc();
    chk("cnt field3 sat", int'(cnt_flat[31:24]), 255);
    in_valid = 1'b1; in_sel = 2'd0; out_ready = 4'h1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h40 + i);
      cyc();
    end
    in_valid = 1'b0; cyc();
    chk("cnt field0", int'(cnt_flat[7:0]), 5);
    out_ready = 4'h0;
    in_valid = 1'b1; in_data = 8'h77; cyc();
    in_valid = 1'b0; out_ready = 4'h1; cnt_clr = 1'b1; cyc();
    cnt_clr = 1'b0;
    chk("cnt clr beats drain", int'(cnt_flat[7:0]), 0);
`endif

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/demux4_reg.md
Name: demux4_reg

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshaking on every channel; the inverse of the team's gate-level 4:1 selector.
- Accepts one word per cycle on a single input channel and delivers it to the output channel chosen by a 2-bit select.
- Each output has its own one-entry holding register, so a stalled consumer blocks only its own channel.
- Sits between a shared producer, such as a bus or datapath result, and four independent consumers.

Parameters:
WIDTH, 8, data word width in bits (>= 1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word on in_data
in_ready  output  1  block accepts the word this cycle
in_data  input  WIDTH  input word
in_sel  input  2  destination channel: 0..3
out_valid  output  4  bit k: channel k holds a word
out_ready  input  4  bit k: consumer k takes the word this cycle
out0_data  output  WIDTH  channel 0 word
out1_data  output  WIDTH  channel 1 word
out2_data  output  WIDTH  channel 2 word
out3_data  output  WIDTH  channel 3 word

Behaviour:
- Reset:
  - rst_n low asynchronously clears out_valid to 4'b0000 and all outK_data to 0; with OPT, also all counters.
  - Words held at reset assertion are discarded.
  - No handshakes occur while rst_n is low; in_ready is 0 during reset.
- Channel state: each channel k has a two-state FSM.
  - EMPTY: out_valid[k]=0.
  - FULL: out_valid[k]=1, outK_data holds the word.
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire[k] = out_valid[k] & out_ready[k].
- in_ready (combinational) = !out_valid[s] | out_ready[s], where s = in_sel.
  - Depends only on the selected channel's state and ready.
  - Does not depend on in_valid.
- Write rule: on in_fire, channel s loads in_data at the next rising edge and is FULL the following cycle.
  - Latency is exactly 1 cycle from in_fire to out_valid[s].
- Channel transitions:
  - EMPTY -> FULL on in_fire with in_sel=k.
  - FULL -> EMPTY on out_fire[k] without a write to k.
  - FULL -> FULL with new data when out_fire[k] and a write to k occur in the same cycle (pass-through, full throughput).
  - FULL stays FULL, holding data, when out_ready[k]=0; a write to k is impossible then because in_ready=0.
- Independence:
  - Channels not addressed by in_sel are unaffected by the input.
  - Any number of channels may drain in the same cycle.
- Data stability:
  - outK_data changes only on a write to channel k.
  - outK_data is stable while out_valid[k] & !out_ready[k].
- Producer rule: in_data and in_sel must be held while in_valid & !in_ready.
  - The block samples only on in_fire and never latches on in_valid alone.
- A word is never duplicated, dropped, or delivered to a channel other than in_sel.

Optional Feature:
Macro: DEMUX4_REG_STATS_EN
- Defined:
  - Adds output port cnt_flat, 32 bits = four 8-bit fields; field k is bits [8k+7:8k].
  - Field k counts out_fire[k] events.
  - Counters saturate at 255 and do not wrap.
  - Cleared by rst_n and by a new input port cnt_clr (1 bit, synchronous, active-high).
  - cnt_clr takes priority over a same-cycle increment.
- Not defined: ports, counters and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset with out_valid forced high mid-operation.
   - Required: out_valid=0000 and outK_data=0 immediately on rst_n fall, without waiting for a clock edge.
2. Single word: in_data=8'hA5, in_sel=2, all out_ready=0.
   - Required: in_ready=1; next cycle out_valid=0100 and out2_data=A5.
   - A second word 8'h3C to channel 2 sees in_ready=0, and out2_data stays A5.
3. Blocked versus free channel.
   - Stimulus: channel 2 FULL with out_ready[2]=0; send 8'h11 with in_sel=0.
   - Required: accepted; out_valid=0101 and out0_data=11.
4. Pass-through: channel 1 FULL holding 8'h01 with out_ready[1]=1; stream 8'h02, 8'h03, 8'h04 to channel 1 on back-to-back cycles.
   - Required: in_ready is held at 1, and the consumer sees 01, 02, 03, 04 on consecutive cycles.
5. Random soak: 10,000 cycles of random in_valid, in_sel and out_ready.
   - Required: the per-channel scoreboard shows no loss, duplication or misroute, and outK_data is stable while stalled.
6. Statistics (DEMUX4_REG_STATS_EN defined).
   - 300 drains on channel 3: field 3 = 255.
   - 5 drains on channel 0: field 0 = 5.
   - cnt_clr pulsed in the same cycle as a drain: field reads 0.
